// File: rtl/zle_pkg.sv
// Shared definitions for the zero run-length codec: FSM states, token types
// and the token type-bit position helper.
package zle_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1
  } state_e;

  localparam logic TOK_LIT = 1'b0;
  localparam logic TOK_RUN = 1'b1;

  // Token layout: {type, payload[w-1:0]}, so the type bit sits at index w.
  function automatic int unsigned type_bit(input int unsigned w);
    return w;
  endfunction

endpackage

// File: rtl/zle_dec_cnt.sv
// Loadable down-counter holding the zeros still owed for the current run,
// with a registered "exactly one left" flag.
module zle_dec_cnt #(
  parameter int unsigned CW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          is_one_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          one_q, one_d;

  // Flag tracks the value being written so is_one is valid the cycle after
  always_comb begin
    cnt_d = cnt_q;
    one_d = one_q;
    if (load_i) begin
      cnt_d = load_val_i;
      one_d = (load_val_i == CW'(1));
    end else if (dec_i) begin
      cnt_d = cnt_q - CW'(1);
      one_d = (cnt_q == CW'(2));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      one_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      one_q <= one_d;
    end
  end

  assign is_one_o = one_q;

endmodule

// File: rtl/zle_dec.sv
// Zero run-length decoder: expands run tokens into zero words, passes literals.
// Optional sticky format-error output enabled by defining ZLE_DEC_ERR_EN.
module zle_dec
  import zle_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned CW      = 8,
  parameter int unsigned MAX_RUN = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_v,
  output logic         i_b,
  input  logic [W:0]   i_d,
  output logic         o_v,
  input  logic         o_b,
  output logic [W-1:0] o_d
`ifdef ZLE_DEC_ERR_EN
  ,
  output logic         err
`endif
);

  localparam int unsigned TYPE_BIT = type_bit(W);

  if (CW < W || MAX_RUN == 0) begin : g_bad_cfg
    $error("zle_dec: CW must be >= W and MAX_RUN must be >= 1");
  end

  state_e        state_q, state_d;
  logic          o_v_q, o_v_d;
  logic [W-1:0]  o_d_q, o_d_d;
  logic          tok_type;
  logic [W-1:0]  payload;
  logic [CW-1:0] n_ext;
  logic          slot_free;
  logic          take;
  logic          cnt_load, cnt_dec, cnt_is_one;

  assign tok_type  = i_d[TYPE_BIT];
  assign payload   = i_d[W-1:0];
  assign n_ext     = CW'(payload);
  assign slot_free = !o_v_q || !o_b;
  assign i_b       = !(state_q == S_IDLE && slot_free);
  assign take      = i_v && !i_b;

  zle_dec_cnt #(.CW(CW)) u_cnt (
    .clock      (clock),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (n_ext - CW'(1)),
    .dec_i      (cnt_dec),
    .is_one_o   (cnt_is_one)
  );

  // Next state and output word; everything holds while the slot is occupied
  always_comb begin
    state_d  = state_q;
    o_v_d    = o_v_q;
    o_d_d    = o_d_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          if (tok_type == TOK_LIT) begin
            o_d_d = payload;
            o_v_d = 1'b1;
          end else if (n_ext != '0) begin
            o_d_d    = '0;
            o_v_d    = 1'b1;
            cnt_load = 1'b1;
            if (n_ext > CW'(1)) state_d = S_RUN;
          end else begin
            o_v_d = 1'b0;
          end
        end else if (slot_free) begin
          o_v_d = 1'b0;
        end
      end
      S_RUN: begin
        if (slot_free) begin
          o_d_d   = '0;
          o_v_d   = 1'b1;
          cnt_dec = 1'b1;
          if (cnt_is_one) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        o_v_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      o_v_q   <= 1'b0;
      o_d_q   <= '0;
    end else begin
      state_q <= state_d;
      o_v_q   <= o_v_d;
      o_d_q   <= o_d_d;
    end
  end

  assign o_v = o_v_q;
  assign o_d = o_d_q;

`ifdef ZLE_DEC_ERR_EN
  logic err_q, err_d;

  // Illegal run lengths are flagged but still decoded normally
  always_comb begin
    err_d = err_q;
    if (take && tok_type == TOK_RUN && (n_ext == '0 || n_ext > CW'(MAX_RUN)))
      err_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule
